// File: rtl/mem_access_if.sv
// Data-bus port between the memory stage (master) and the data memory/bus (slave).
interface mem_access_if #(parameter int DW = 64);
    logic          dreq_valid;
    logic [DW-1:0] dreq_addr;
    logic [1:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [DW-1:0] dreq_data;
    logic          dresp_ok;
    logic [DW-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_ok, dresp_data
    );
    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_ok, dresp_data
    );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access unit: one bus transaction per load/store, pipeline stall
// until completion, load alignment/extension and misalignment detection.
module mem_access #(parameter int DW = 64) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic          op_load,
    input  logic          op_store,
    input  logic [1:0]    op_size,
    input  logic          op_unsigned,
    input  logic [DW-1:0] op_addr,
    input  logic [DW-1:0] op_wdata,
    input  logic          advance,
    input  logic          flush,
    mem_access_if.master  bus,
    output logic [DW-1:0] rdata,
    output logic          misalign,
    output logic          stall_req
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] lat_addr_q, lat_addr_d;
    logic [1:0]    lat_size_q, lat_size_d;
    logic [7:0]    lat_strobe_q, lat_strobe_d;
    logic [DW-1:0] lat_data_q, lat_data_d;

    logic          mem_op, mis, issue, done, to_hold;
    logic [2:0]    off;
    logic [7:0]    strb_base, cur_strobe;
    logic [DW-1:0] cur_data, sh, ext;
    logic          sx;

    assign mem_op = op_valid & (op_load | op_store);
    assign off    = op_addr[2:0];

    always_comb begin
        mis       = 1'b0;
        strb_base = 8'h01;
        case (op_size)
            2'd0: begin mis = 1'b0;          strb_base = 8'h01; end
            2'd1: begin mis = op_addr[0];    strb_base = 8'h03; end
            2'd2: begin mis = |op_addr[1:0]; strb_base = 8'h0F; end
            default: begin mis = |op_addr[2:0]; strb_base = 8'hFF; end
        endcase
    end

    assign cur_strobe = op_store ? (strb_base << off) : 8'h00;
    assign cur_data   = op_wdata << {off, 3'b000};

    // Load lane extraction: shift the addressed byte down to bit 0, then extend.
    assign sh = bus.dresp_data >> {off, 3'b000};
    assign sx = ~op_unsigned;
    always_comb begin
        ext = sh;
        case (op_size)
            2'd0:    ext = {{(DW-8){sx & sh[7]}},   sh[7:0]};
            2'd1:    ext = {{(DW-16){sx & sh[15]}}, sh[15:0]};
            2'd2:    ext = {{(DW-32){sx & sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
    end

    assign issue    = mem_op & ~mis & ~flush;
    assign misalign = mem_op & mis;

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        lat_addr_d     = lat_addr_q;
        lat_size_d     = lat_size_q;
        lat_strobe_d   = lat_strobe_q;
        lat_data_d     = lat_data_q;
        done           = 1'b0;
        to_hold        = 1'b0;
        stall_req      = 1'b0;
        bus.dreq_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.dreq_valid = issue;
                stall_req      = mem_op & ~mis & ~bus.dresp_ok;
                if (issue) begin
                    if (bus.dresp_ok) begin
                        done    = 1'b1;
                        to_hold = ~advance;
                        state_d = advance ? S_IDLE : S_HOLD;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                bus.dreq_valid = 1'b1;
                stall_req      = ~bus.dresp_ok;
                if (bus.dresp_ok) begin
                    done    = 1'b1;
                    to_hold = ~advance & ~flush;
                    state_d = (advance | flush) ? S_IDLE : S_HOLD;
                end else if (flush) begin
                    // EX/MEM may change once flushed, so freeze the payload now.
                    lat_addr_d   = op_addr;
                    lat_size_d   = op_size;
                    lat_strobe_d = cur_strobe;
                    lat_data_d   = cur_data;
                    state_d      = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (advance | flush) state_d = S_IDLE;
            end
            default: begin
                bus.dreq_valid = 1'b1;
                stall_req      = 1'b1;
                if (bus.dresp_ok) state_d = S_IDLE;
            end
        endcase

        if (to_hold) rdata_d = op_load ? ext : '0;
    end

    always_comb begin
        rdata = '0;
        if (state_q == S_HOLD)  rdata = rdata_q;
        else if (done & op_load) rdata = ext;
    end

    always_comb begin
        if (state_q == S_DRAIN) begin
            bus.dreq_addr   = lat_addr_q;
            bus.dreq_size   = lat_size_q;
            bus.dreq_strobe = lat_strobe_q;
            bus.dreq_data   = lat_data_q;
        end else begin
            bus.dreq_addr   = op_addr;
            bus.dreq_size   = op_size;
            bus.dreq_strobe = cur_strobe;
            bus.dreq_data   = cur_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rdata_q      <= '0;
            lat_addr_q   <= '0;
            lat_size_q   <= '0;
            lat_strobe_q <= '0;
            lat_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            lat_addr_q   <= lat_addr_d;
            lat_size_q   <= lat_size_d;
            lat_strobe_q <= lat_strobe_d;
            lat_data_q   <= lat_data_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs change on the falling edge, outputs
// are checked 1 time unit later, state advances on the rising edge.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_load, op_store, op_unsigned, advance, flush;
    logic [1:0]  op_size;
    logic [63:0] op_addr, op_wdata, rdata;
    logic        misalign, stall_req;
    int          nvec = 0;
    int          nerr = 0;

    mem_access_if #(.DW(64)) bus();

    mem_access #(.DW(64)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .advance(advance), .flush(flush),
        .bus(bus),
        .rdata(rdata), .misalign(misalign), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd);
        op_valid = v; op_load = ld; op_store = st; op_size = sz;
        op_unsigned = uns; op_addr = a; op_wdata = wd;
    endtask

    task automatic set_bus(input logic ok, input logic [63:0] d);
        bus.dresp_ok = ok; bus.dresp_data = d;
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; advance = 1'b0; flush = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        set_bus(0, 0);
        #1;
        chk("rst_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("rst_stall",  {63'd0, stall_req}, 0);
        chk("rst_rdata",  rdata, 0);
        chk("rst_mis",    {63'd0, misalign}, 0);
        nxt; reset = 1'b1; nxt;

        // load byte signed at 0x1003, response in cycle 3
        set_op(1, 1, 0, 0, 0, 64'h1003, 0); #1;
        chk("lb_c0_dvalid", {63'd0, bus.dreq_valid}, 1);
        chk("lb_c0_stall",  {63'd0, stall_req}, 1);
        chk("lb_c0_strobe", {56'd0, bus.dreq_strobe}, 0);
        chk("lb_c0_addr",   bus.dreq_addr, 64'h1003);
        nxt; #1;
        chk("lb_c1_stall",  {63'd0, stall_req}, 1);
        nxt; #1;
        chk("lb_c2_stall",  {63'd0, stall_req}, 1);
        chk("lb_c2_dvalid", {63'd0, bus.dreq_valid}, 1);
        nxt; set_bus(1, 64'h00000000_80000000); advance = 1'b1; #1;
        chk("lb_c3_stall",  {63'd0, stall_req}, 0);
        chk("lb_c3_rdata",  rdata, 64'hFFFFFFFF_FFFFFF80);
        nxt; set_bus(0, 0); advance = 1'b0; set_op(0, 0, 0, 0, 0, 0, 0); #1;
        chk("lb_c4_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("lb_c4_rdata",  rdata, 0);

        // store half at 0x2006, zero-wait
        nxt; set_op(1, 0, 1, 1, 0, 64'h2006, 64'hBEEF); set_bus(1, 0); advance = 1'b1; #1;
        chk("sh_strobe", {56'd0, bus.dreq_strobe}, 64'hC0);
        chk("sh_data",   bus.dreq_data, 64'hBEEF0000_00000000);
        chk("sh_stall",  {63'd0, stall_req}, 0);
        chk("sh_dvalid", {63'd0, bus.dreq_valid}, 1);
        nxt; set_bus(0, 0); set_op(0, 0, 0, 0, 0, 0, 0); #1;
        chk("sh_after_dvalid", {63'd0, bus.dreq_valid}, 0);

        // misaligned load word
        nxt; set_op(1, 1, 0, 2, 0, 64'h2002, 0); #1;
        chk("mis_flag",   {63'd0, misalign}, 1);
        chk("mis_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("mis_stall",  {63'd0, stall_req}, 0);
        nxt; set_op(0, 0, 0, 0, 0, 0, 0); advance = 1'b0; #1;
        chk("mis_clear", {63'd0, misalign}, 0);

        // load dword zero-wait without advance -> HOLD for 2 cycles
        nxt; set_op(1, 1, 0, 3, 1, 64'h3000, 0); set_bus(1, 64'h11223344_55667788); #1;
        chk("ld_c0_rdata", rdata, 64'h11223344_55667788);
        chk("ld_c0_stall", {63'd0, stall_req}, 0);
        nxt; set_bus(0, 64'hDEADDEAD_DEADDEAD); #1;
        chk("ld_h1_rdata",  rdata, 64'h11223344_55667788);
        chk("ld_h1_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("ld_h1_stall",  {63'd0, stall_req}, 0);
        nxt; advance = 1'b1; #1;
        chk("ld_h2_rdata",  rdata, 64'h11223344_55667788);
        chk("ld_h2_dvalid", {63'd0, bus.dreq_valid}, 0);
        // back in IDLE: load half unsigned issues immediately
        nxt; set_op(1, 1, 0, 1, 1, 64'h4002, 0); set_bus(1, 64'h00000000_ABCD0000); #1;
        chk("lhu_dvalid", {63'd0, bus.dreq_valid}, 1);
        chk("lhu_rdata",  rdata, 64'h00000000_0000ABCD);
        nxt; set_op(1, 1, 0, 2, 0, 64'h4004, 0); set_bus(1, 64'h87654321_00000000); #1;
        chk("lw_rdata", rdata, 64'hFFFFFFFF_87654321);

        // flush during BUSY load, response in cycle 4
        nxt; set_bus(0, 0); advance = 1'b0; set_op(1, 1, 0, 2, 0, 64'h5000, 0); #1;
        chk("fl_c0_stall", {63'd0, stall_req}, 1);
        nxt; flush = 1'b1; #1;
        chk("fl_c1_stall", {63'd0, stall_req}, 1);
        nxt; flush = 1'b0; set_op(1, 0, 1, 3, 0, 64'h9990, 64'hFFFFFFFF_FFFFFFFF); #1;
        chk("fl_c2_stall",  {63'd0, stall_req}, 1);
        chk("fl_c2_dvalid", {63'd0, bus.dreq_valid}, 1);
        chk("fl_c2_addr",   bus.dreq_addr, 64'h5000);
        chk("fl_c2_size",   {62'd0, bus.dreq_size}, 2);
        chk("fl_c2_strobe", {56'd0, bus.dreq_strobe}, 0);
        chk("fl_c2_data",   bus.dreq_data, 0);
        nxt; set_op(0, 0, 0, 0, 0, 0, 0); advance = 1'b1; #1;
        chk("fl_c3_stall", {63'd0, stall_req}, 1);
        nxt; set_bus(1, 64'h12345678_12345678); #1;
        chk("fl_c4_stall", {63'd0, stall_req}, 1);
        chk("fl_c4_addr",  bus.dreq_addr, 64'h5000);
        chk("fl_c4_rdata", rdata, 0);
        nxt; set_op(1, 1, 0, 0, 1, 64'h6001, 0); set_bus(1, 64'h00000000_0000FF00); #1;
        chk("fl_c5_dvalid", {63'd0, bus.dreq_valid}, 1);
        chk("fl_c5_stall",  {63'd0, stall_req}, 0);
        chk("fl_c5_rdata",  rdata, 64'hFF);

        // reset pulse while BUSY
        nxt; set_bus(0, 0); advance = 1'b0; set_op(1, 1, 0, 3, 0, 64'h7000, 0); #1;
        chk("rb_c0_stall", {63'd0, stall_req}, 1);
        nxt; #1;
        chk("rb_c1_dvalid", {63'd0, bus.dreq_valid}, 1);
        #1; reset = 1'b0; set_op(0, 0, 0, 0, 0, 0, 0); #1;
        chk("rb_rst_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("rb_rst_stall",  {63'd0, stall_req}, 0);
        nxt; reset = 1'b1; nxt; #1;
        chk("rb_post_dvalid", {63'd0, bus.dreq_valid}, 0);
        chk("rb_post_rdata",  rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data-access unit of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns a load/store from EX/MEM into a single data-bus transaction, holds the pipeline until the transaction completes, and aligns and extends load data. It produces the result and exception fields that the MEM/WB register captures.

## Interface
- `DW`, default 64: data and address width.
- `clk` in, 1: clock, rising edge.
- `reset` in, 1: asynchronous, active-low. State is cleared while `reset`=0.
- `op_valid` in, 1: the EX/MEM entry is valid.
- `op_load` in, 1: the entry is a load.
- `op_store` in, 1: the entry is a store. `op_load` and `op_store` are never both 1.
- `op_size` in, 2: access size. 0=byte, 1=half, 2=word, 3=dword.
- `op_unsigned` in, 1: zero-extend load data. When 0, sign-extend.
- `op_addr` in, DW: byte address.
- `op_wdata` in, DW: store data, right-aligned.
- `advance` in, 1: MEM/WB captures this cycle. The current entry retires.
- `flush` in, 1: discard the current entry.
- `dreq_valid` out, 1: bus request.
- `dreq_addr` out, DW: `op_addr`, passed through.
- `dreq_size` out, 2: `op_size`, passed through.
- `dreq_strobe` out, 8: byte-write enables. Zero for loads.
- `dreq_data` out, DW: lane-shifted store data.
- `dresp_ok` in, 1: one-cycle completion pulse.
- `dresp_data` in, DW: read data, valid when `dresp_ok`=1.
- `rdata` out, DW: aligned, extended load result.
- `misalign` out, 1: address-misaligned exception for the current entry.
- `stall_req` out, 1: hold all stages up to and including EX/MEM.

## Operation
- `mem_op` = `op_valid` & (`op_load` | `op_store`).
- `mis` = `op_addr` not aligned to 2^`op_size` bytes.
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: request outstanding.
  - HOLD: transaction complete, waiting for `advance`.
  - DRAIN: flushed while BUSY, waiting for `dresp_ok`.
- Transitions:
  - IDLE, `mem_op` & !`mis` & !`flush`: `dreq_valid`=1 this cycle. If `dresp_ok`=1 the same cycle, go to HOLD, or stay in IDLE if `advance`=1. Otherwise go to BUSY.
  - BUSY: `dreq_valid`=1 with payload held stable. On `dresp_ok`, go to IDLE if `advance`=1, else HOLD. If `flush`=1 without `dresp_ok`, go to DRAIN. If `flush` and `dresp_ok` coincide, go to IDLE.
  - HOLD: `dreq_valid`=0. Go to IDLE on `advance` or `flush`.
  - DRAIN: `dreq_valid`=1 with the original payload (latched on entry). On `dresp_ok`, discard the data and go to IDLE. `flush` and `advance` are ignored.
- `stall_req` = (IDLE & `mem_op` & !`mis` & !`dresp_ok`) | (BUSY & !`dresp_ok`) | DRAIN.
- `misalign` = `mem_op` & `mis`, combinational. No bus request is issued and no stall occurs.
- Store:
  - `dreq_data` = `op_wdata` << (8·`op_addr[2:0]`).
  - `dreq_strobe` = ((1<<2^`op_size`)−1) << `op_addr[2:0]`, truncated to 8 bits.
- Load:
  - Shift `dresp_data` right by 8·`op_addr[2:0]`.
  - Keep the low 8·2^`op_size` bits.
  - Extend to DW using `op_unsigned`.
- `rdata` = the extended value directly in the `dresp_ok` cycle. In HOLD, `rdata` is the registered copy. Otherwise `rdata` = 0.

## Timing
- Reset values: state=IDLE, held `rdata` register=0, DRAIN payload=0. All outputs then follow the IDLE equations.
- A zero-wait bus completes a load in 0 extra cycles: `dresp_ok` in the issue cycle, `stall_req`=0, and MEM/WB captures `rdata` that cycle.
- An N-cycle bus gives exactly N stall cycles.
- `dreq_*` stays stable from the first `dreq_valid` until `dresp_ok`, including across `flush`. DRAIN uses the latched copy.
- A new request can issue the cycle after leaving DRAIN, HOLD or BUSY.
- Reset asserted mid-transaction aborts to IDLE immediately. Bus recovery is handled by the bus side.
- A non-memory entry (`mem_op`=0) has no effect in IDLE.

## Test plan
- Load byte, addr=0x1003, `op_unsigned`=0, `dresp_data`=0x00000000_80000000, `dresp_ok` in cycle 3 -> `stall_req`=1 for cycles 0–2, `rdata`=0xFFFFFFFF_FFFFFF80 in cycle 3.
- Store half, addr=0x2006, wdata=0xBEEF, `dresp_ok` in cycle 0 -> `dreq_strobe`=0xC0, `dreq_data`=0xBEEF0000_00000000, no stall.
- Load word, addr=0x2002 -> `misalign`=1, `dreq_valid`=0, `stall_req`=0.
- Load dword completes while `advance`=0 for 2 cycles -> state is HOLD, `rdata` holds its value and `dreq_valid`=0. `advance` returns the FSM to IDLE.
- `flush` in cycle 1 of a BUSY load, `dresp_ok` in cycle 4 -> DRAIN with `stall_req`=1 through cycle 4, data discarded, IDLE in cycle 5.
- `reset`=0 pulse while BUSY -> IDLE, `dreq_valid`=0 and `stall_req`=0 immediately.
